rx_byte_fifo: RTL and testbench



---
 rtl/calc_pkg.sv | 24 ++
 rtl/sync_fifo_fwft.sv | 94 +++++++++
 rtl/rx_byte_fifo.sv | 96 +++++++++
 tb/tb_rx_byte_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared ASCII constants and character classification for the calculator path.
package calc_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_MUL   = 8'h2A;
  localparam logic [7:0] ASC_DIV   = 8'h2F;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_CLR   = 8'h63;

  // True for the characters the calculator understands: digits, operators,
  // '=' and the clear key.
  function automatic logic is_calc_char(input logic [7:0] b);
    logic is_digit;
    logic is_op;
    is_digit = (b >= ASC_0) && (b <= ASC_9);
    is_op    = (b == ASC_PLUS) || (b == ASC_MINUS) || (b == ASC_MUL) ||
               (b == ASC_DIV)  || (b == ASC_EQ)    || (b == ASC_CLR);
    return is_digit || is_op;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Small first-word-fall-through FIFO with a flush-and-write input.
// A flush discards all queued entries and stores wdata_i as the only entry,
// which lets a clear key replace the queue in a single edge.
module sync_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Guard the handshakes locally so the occupancy can never leave 0..DEPTH
  // even if a caller asks for an illegal push or pop.
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    if (flush_i) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = ADDR_W'(1);
      count_d   = (ADDR_W+1)'(1);
      mem_we    = 1'b1;
      mem_waddr = '0;
    end else begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; contents are dropped on reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= wdata_i;
    end
  end

  assign out_valid_o = ~empty;
  assign out_data_o  = mem[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive buffer between the UART receiver and the calculator FSM.
// Turns the receiver's level valid into one request per byte, drops bytes the
// calculator cannot use, flushes on the clear key and flags lost bytes.
// DEPTH must be a power of two and at least 2.
module rx_byte_fifo
  import calc_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter bit FILTER_EN      = 1'b1,
  parameter bit FLUSH_ON_CLEAR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic rx_valid_q;
  logic overflow_q, overflow_d;
  logic push_req;
  logic accepted;
  logic is_clr;
  logic flush;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Previous rx_valid; resets high so a valid already asserted at reset
  // release is not mistaken for a new byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_valid_q <= 1'b1;
    end else begin
      rx_valid_q <= rx_valid;
    end
  end

  // Request, filter and admission decisions for the current byte.
  always_comb begin
    push_req = rx_valid & ~rx_valid_q;
    accepted = FILTER_EN ? is_calc_char(rx_data) : 1'b1;
    is_clr   = FLUSH_ON_CLEAR & (rx_data == ASC_CLR);
    full     = (count == DEPTH_C);
    pop      = out_valid & out_ready;
    flush    = push_req & accepted & is_clr;
    push     = push_req & accepted & ~is_clr & (~full | pop);
    drop     = push_req & accepted & ~is_clr & full & ~pop;
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .flush_i     (flush),
    .wdata_i     (rx_data),
    .pop_i       (pop),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .count_o     (count)
  );

  assign overflow = overflow_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo: byte table plus hand-written corner cases.
module tb_rx_byte_fifo;

  logic       clk;
  logic       rstn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  rx_byte_fifo #(
    .DEPTH          (8),
    .FILTER_EN      (1'b1),
    .FLUSH_ON_CLEAR (1'b1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [7:0] data;
    int         exp_count;
    logic       exp_valid;
    logic [7:0] exp_head;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    rx_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
  endtask

  // rx_valid held for 4 cycles per byte, as the receiver does.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string name, input logic [7:0] exp[$]);
    @(negedge clk);
    out_ready = 1'b1;
    foreach (exp[i]) begin
      chk({name, "_valid"}, 32'(out_valid), 1);
      chk({name, "_data"}, 32'(out_data), 32'(exp[i]));
      @(negedge clk);
    end
    chk({name, "_empty"}, 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  task automatic add(input logic r, input logic [7:0] d, input int c,
                     input logic v, input logic [7:0] h, input logic o);
    vec_t t;
    t.do_rst = r; t.data = d; t.exp_count = c;
    t.exp_valid = v; t.exp_head = h; t.exp_ovf = o;
    vecs.push_back(t);
  endtask

  initial begin
    logic [7:0] q[$];

    rstn      = 1'b0;
    rx_valid  = 1'b1;
    rx_data   = 8'h35;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    // rx_valid already high across reset release must not be captured.
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_count", 32'(count), 0);
    chk("hold_valid", 32'(out_valid), 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_count2", 32'(count), 0);

    // Basic ordering
    add(1'b0, 8'h37, 1, 1'b1, 8'h37, 1'b0);
    add(1'b0, 8'h2B, 2, 1'b1, 8'h37, 1'b0);
    add(1'b0, 8'h33, 3, 1'b1, 8'h37, 1'b0);
    add(1'b0, 8'h3D, 4, 1'b1, 8'h37, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      send_byte(vecs[i].data);
      chk($sformatf("ord%0d_count", i), 32'(count), vecs[i].exp_count);
      chk($sformatf("ord%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("ord%0d_head", i), 32'(out_data), 32'(vecs[i].exp_head));
      chk($sformatf("ord%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end
    q = '{8'h37, 8'h2B, 8'h33, 8'h3D};
    drain("order_drain", q);

    // Filtering, overflow fill, and clear-when-full, all table driven
    vecs.delete();
    add(1'b1, 8'h20, 0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h0D, 0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h78, 0, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h34, 1, 1'b1, 8'h34, 1'b0);
    for (int k = 0; k < 8; k++)
      add(k == 0, 8'h31 + 8'(k), k + 1, 1'b1, 8'h31, 1'b0);
    add(1'b0, 8'h63, 1, 1'b1, 8'h63, 1'b0);
    add(1'b0, 8'h39, 2, 1'b1, 8'h63, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      send_byte(vecs[i].data);
      chk($sformatf("tab%0d_count", i), 32'(count), vecs[i].exp_count);
      chk($sformatf("tab%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("tab%0d_head", i), 32'(out_data), 32'(vecs[i].exp_head));
      chk($sformatf("tab%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end

    // Overflow: '1'..'9' into an 8-deep FIFO, ninth byte is lost
    do_reset();
    for (int k = 0; k < 9; k++) send_byte(8'h31 + 8'(k));
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(out_data), 32'h31);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);

    // Drop and clear in the same cycle: set wins
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h39; ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("setwins_ovf", 32'(overflow), 1);
    chk("setwins_count", 32'(count), 8);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 0);

    // Full with simultaneous pop: push of '0' succeeds
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h30; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("fullpop_count", 32'(count), 8);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_head", 32'(out_data), 32'h32);
    q = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h30};
    drain("fullpop_drain", q);

    // Flush on clear
    do_reset();
    send_byte(8'h32);
    send_byte(8'h2A);
    send_byte(8'h36);
    chk("preflush_count", 32'(count), 3);
    send_byte(8'h63);
    chk("flush_count", 32'(count), 1);
    chk("flush_head", 32'(out_data), 32'h63);
    send_byte(8'h35);
    chk("postflush_count", 32'(count), 2);
    q = '{8'h63, 8'h35};
    drain("flush_drain", q);

    // Reset mid-operation discards contents
    send_byte(8'h31);
    send_byte(8'h32);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
